// File: rtl/xl320_status_rx_if.sv
// rtl/xl320_status_rx_if.sv - controller/UART side signals of the XL-320 status packet receiver
// The master side arms the parser and feeds UART bytes; the slave side is the parser itself.
interface xl320_status_rx_if #(
   parameter int MAX_PARAMS = 4
);
   logic                    arm;
   logic [7:0]              expected_id;
   logic                    rx_valid;
   logic [7:0]              rx_byte;
   logic                    busy;
   logic                    done;
   logic [2:0]              result;
   logic [7:0]              rx_id;
   logic [7:0]              rx_error;
   logic [7:0]              param_count;
   logic [8*MAX_PARAMS-1:0] params;

   modport master (
      output arm, expected_id, rx_valid, rx_byte,
      input  busy, done, result, rx_id, rx_error, param_count, params
   );

   modport slave (
      input  arm, expected_id, rx_valid, rx_byte,
      output busy, done, result, rx_id, rx_error, param_count, params
   );
endinterface

// File: rtl/xl320_status_rx.sv
// rtl/xl320_status_rx.sv - Dynamixel 2.0 status packet parser (header hunt, de-stuffing, CRC-16)
// One byte per rx_valid; completion reported by a registered done pulse and result code.
module xl320_status_rx #(
   parameter int MAX_PARAMS     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               clock,
   input  logic               reset,
   xl320_status_rx_if.slave   bus
);
   localparam logic [2:0] RES_OK    = 3'd0;
   localparam logic [2:0] RES_CRC   = 3'd1;
   localparam logic [2:0] RES_TMO   = 3'd2;
   localparam logic [2:0] RES_ID    = 3'd3;
   localparam logic [2:0] RES_INSTR = 3'd4;
   localparam logic [2:0] RES_LEN   = 3'd5;
   localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);
   localparam int             PW       = 8 * MAX_PARAMS;

   typedef enum logic [3:0] {
      S_IDLE, S_H1, S_H2, S_H3, S_H4, S_ID, S_LEN_L, S_LEN_H,
      S_INSTR, S_ERR, S_PARAM, S_CRC_L, S_CRC_H
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     crc_q, crc_d;
   logic [15:0]     len_q, len_d;
   logic [7:0]      crc_lo_q, crc_lo_d;
   logic [7:0]      instr_q, instr_d;
   logic [7:0]      exp_id_q, exp_id_d;
   logic [7:0]      id_q, id_d;
   logic [7:0]      err_q, err_d;
   logic [7:0]      pcnt_q, pcnt_d;
   logic [23:0]     hist_q, hist_d;
   logic            ovf_q, ovf_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [2:0]      result_q, result_d;
   logic [PW-1:0]   params_q, params_d;
   logic [CW-1:0]   tmo_q, tmo_d;

   logic [15:0]     crc_b;
   logic [15:0]     crc_ff;
   logic [15:0]     len_full;
   logic            finish;
   logic [2:0]      finish_code;

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
      end
      return r;
   endfunction

   assign crc_b    = crc_upd(crc_q, bus.rx_byte);
   assign crc_ff   = crc_upd(16'h0000, 8'hFF);
   assign len_full = {bus.rx_byte, len_q[7:0]};

   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      len_d       = len_q;
      crc_lo_d    = crc_lo_q;
      instr_d     = instr_q;
      exp_id_d    = exp_id_q;
      id_d        = id_q;
      err_d       = err_q;
      pcnt_d      = pcnt_q;
      hist_d      = hist_q;
      ovf_d       = ovf_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      result_d    = result_q;
      params_d    = params_q;
      tmo_d       = tmo_q;
      finish      = 1'b0;
      finish_code = RES_OK;

      if (bus.arm) begin
         state_d  = S_H1;
         busy_d   = 1'b1;
         tmo_d    = TMO_LOAD;
         exp_id_d = bus.expected_id;
         crc_d    = 16'h0000;
         id_d     = 8'h00;
         err_d    = 8'h00;
         pcnt_d   = 8'h00;
         params_d = '0;
         ovf_d    = 1'b0;
         hist_d   = 24'h000000;
      end else if (busy_q && bus.rx_valid) begin
         tmo_d = TMO_LOAD;
         unique case (state_q)
            // The hunt is a pattern matcher for FF FF FD 00; the CRC always equals
            // the CRC of the header prefix currently matched, so restarts stay exact.
            S_H1: begin
               if (bus.rx_byte == 8'hFF) begin
                  state_d = S_H2;
                  crc_d   = crc_ff;
               end else begin
                  crc_d = 16'h0000;
               end
            end
            S_H2: begin
               if (bus.rx_byte == 8'hFF) begin
                  state_d = S_H3;
                  crc_d   = crc_b;
               end else begin
                  state_d = S_H1;
                  crc_d   = 16'h0000;
               end
            end
            S_H3: begin
               if (bus.rx_byte == 8'hFD) begin
                  state_d = S_H4;
                  crc_d   = crc_b;
               end else if (bus.rx_byte != 8'hFF) begin
                  state_d = S_H1;
                  crc_d   = 16'h0000;
               end
            end
            S_H4: begin
               if (bus.rx_byte == 8'h00) begin
                  state_d = S_ID;
                  crc_d   = crc_b;
               end else if (bus.rx_byte == 8'hFF) begin
                  state_d = S_H2;
                  crc_d   = crc_ff;
               end else begin
                  state_d = S_H1;
                  crc_d   = 16'h0000;
               end
            end
            S_ID: begin
               id_d    = bus.rx_byte;
               crc_d   = crc_b;
               hist_d  = {hist_q[15:0], bus.rx_byte};
               state_d = S_LEN_L;
            end
            S_LEN_L: begin
               len_d   = {8'h00, bus.rx_byte};
               crc_d   = crc_b;
               hist_d  = {hist_q[15:0], bus.rx_byte};
               state_d = S_LEN_H;
            end
            S_LEN_H: begin
               crc_d  = crc_b;
               hist_d = {hist_q[15:0], bus.rx_byte};
               if (len_full < 16'd4) begin
                  finish      = 1'b1;
                  finish_code = RES_LEN;
               end else begin
                  len_d   = len_full;
                  state_d = S_INSTR;
               end
            end
            S_INSTR: begin
               instr_d = bus.rx_byte;
               len_d   = len_q - 16'd1;
               crc_d   = crc_b;
               hist_d  = {hist_q[15:0], bus.rx_byte};
               state_d = S_ERR;
            end
            S_ERR: begin
               err_d   = bus.rx_byte;
               len_d   = len_q - 16'd1;
               crc_d   = crc_b;
               hist_d  = {hist_q[15:0], bus.rx_byte};
               state_d = (len_q == 16'd3) ? S_CRC_L : S_PARAM;
            end
            S_PARAM: begin
               len_d  = len_q - 16'd1;
               crc_d  = crc_b;
               hist_d = {hist_q[15:0], bus.rx_byte};
               // len_q counts what is still to come including this byte and both CRC bytes
               if (!(hist_q == 24'hFFFFFD && bus.rx_byte == 8'hFD)) begin
                  if ({24'd0, pcnt_q} < 32'(MAX_PARAMS)) begin
                     for (int k = 0; k < MAX_PARAMS; k++) begin
                        if (pcnt_q == 8'(k)) params_d[8*k +: 8] = bus.rx_byte;
                     end
                  end else begin
                     ovf_d = 1'b1;
                  end
                  if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
               end
               if (len_q == 16'd3) state_d = S_CRC_L;
            end
            S_CRC_L: begin
               crc_lo_d = bus.rx_byte;
               state_d  = S_CRC_H;
            end
            S_CRC_H: begin
               finish = 1'b1;
               if ({bus.rx_byte, crc_lo_q} != crc_q) finish_code = RES_CRC;
               else if (id_q != exp_id_q)           finish_code = RES_ID;
               else if (instr_q != 8'h55)           finish_code = RES_INSTR;
               else if (ovf_q)                      finish_code = RES_LEN;
               else                                 finish_code = RES_OK;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else if (busy_q) begin
         if (tmo_q == '0) begin
            finish      = 1'b1;
            finish_code = RES_TMO;
         end else begin
            tmo_d = tmo_q - 1'b1;
         end
      end

      if (finish) begin
         done_d   = 1'b1;
         busy_d   = 1'b0;
         state_d  = S_IDLE;
         result_d = finish_code;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         crc_q    <= 16'h0000;
         len_q    <= 16'h0000;
         crc_lo_q <= 8'h00;
         instr_q  <= 8'h00;
         exp_id_q <= 8'h00;
         id_q     <= 8'h00;
         err_q    <= 8'h00;
         pcnt_q   <= 8'h00;
         hist_q   <= 24'h000000;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 3'd0;
         params_q <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         crc_q    <= crc_d;
         len_q    <= len_d;
         crc_lo_q <= crc_lo_d;
         instr_q  <= instr_d;
         exp_id_q <= exp_id_d;
         id_q     <= id_d;
         err_q    <= err_d;
         pcnt_q   <= pcnt_d;
         hist_q   <= hist_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         params_q <= params_d;
         tmo_q    <= tmo_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.rx_id       = id_q;
   assign bus.rx_error    = err_q;
   assign bus.param_count = pcnt_q;
   assign bus.params      = params_q;
endmodule

// File: tb/tb_xl320_status_rx.sv
// tb/tb_xl320_status_rx.sv - bench for xl320_status_rx against a byte-list packet model
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_xl320_status_rx;
   localparam int MAXP = 4;
   localparam int TMO  = 50000;

   typedef logic [7:0] bq_t[$];

   logic clock;
   logic reset;
   xl320_status_rx_if #(.MAX_PARAMS(MAXP)) bus ();

   xl320_status_rx #(.MAX_PARAMS(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   int cyc      = 0;
   int done_cyc = 0;
   int last_evt = 0;
   logic [15:0] tbl [256];

   // model of the expected outputs
   logic        m_busy  = 1'b0;
   logic        m_found = 1'b0;
   int          m_quiet = 0;
   int          m_len   = 0;
   logic [7:0]  m_exp   = 8'h00;
   logic [7:0]  win [4];
   bq_t         pk;
   logic        e_done   = 1'b0;
   logic [2:0]  e_result = 3'd0;
   logic [7:0]  e_id     = 8'h00;
   logic [7:0]  e_err    = 8'h00;
   int          e_pcnt   = 0;
   logic [31:0] e_params = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] crc_of(input bq_t q);
      logic [15:0] c;
      c = 16'h0000;
      foreach (q[i]) c = (c << 8) ^ tbl[(c[15:8] ^ q[i])];
      return c;
   endfunction

   task automatic m_finish(input logic [2:0] code);
      e_done   = 1'b1;
      e_result = code;
      m_busy   = 1'b0;
      m_found  = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      int   n;
      bq_t  cq;
      logic [15:0] rcv;
      if (!m_found) begin
         win[0] = win[1]; win[1] = win[2]; win[2] = win[3]; win[3] = b;
         if (win[0] == 8'hFF && win[1] == 8'hFF && win[2] == 8'hFD && win[3] == 8'h00) begin
            m_found = 1'b1;
            pk.delete();
         end
         return;
      end
      pk.push_back(b);
      n = pk.size();
      if (n == 1) e_id = b;
      else if (n == 3) begin
         m_len = {pk[2], pk[1]};
         if (m_len < 4) m_finish(3'd5);
      end else if (n == 5) e_err = b;
      else if (n >= 6 && n <= m_len + 1) begin
         if (!(b == 8'hFD && pk[n-4] == 8'hFF && pk[n-3] == 8'hFF && pk[n-2] == 8'hFD)) begin
            if (e_pcnt < MAXP) e_params[8*e_pcnt +: 8] = b;
            e_pcnt++;
         end
      end else if (n == m_len + 3) begin
         cq = '{8'hFF, 8'hFF, 8'hFD, 8'h00};
         for (int i = 0; i < n - 2; i++) cq.push_back(pk[i]);
         rcv = {pk[n-1], pk[n-2]};
         if (crc_of(cq) != rcv)  m_finish(3'd1);
         else if (e_id != m_exp) m_finish(3'd3);
         else if (pk[3] != 8'h55) m_finish(3'd4);
         else if (e_pcnt > MAXP) m_finish(3'd5);
         else                    m_finish(3'd0);
      end
   endtask

   task automatic model_step();
      e_done = 1'b0;
      if (!reset) begin
         m_busy = 1'b0; m_found = 1'b0; m_quiet = 0;
         e_result = 3'd0; e_id = 8'h00; e_err = 8'h00; e_pcnt = 0; e_params = 32'h0;
         return;
      end
      if (bus.arm) begin
         m_busy = 1'b1; m_found = 1'b0; m_quiet = 0; m_exp = bus.expected_id;
         for (int i = 0; i < 4; i++) win[i] = 8'h00;
         e_id = 8'h00; e_err = 8'h00; e_pcnt = 0; e_params = 32'h0;
      end else if (m_busy) begin
         if (bus.rx_valid) begin
            m_quiet = 0;
            model_byte(bus.rx_byte);
         end else begin
            m_quiet++;
            if (m_quiet >= TMO) m_finish(3'd2);
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
      model_step();
   end

   initial forever begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
      end
      chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      chk("done", {31'd0, bus.done}, {31'd0, e_done});
      chk("rx_id", {24'd0, bus.rx_id}, {24'd0, e_id});
      chk("rx_error", {24'd0, bus.rx_error}, {24'd0, e_err});
      chk("param_count", {24'd0, bus.param_count}, 32'(e_pcnt));
      chk("params", bus.params, e_params);
      if (!m_busy) chk("result", {29'd0, bus.result}, {29'd0, e_result});
   end

   task automatic do_arm(input logic [7:0] id);
      bus.arm = 1'b1;
      bus.expected_id = id;
      @(negedge clock);
      bus.arm = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      @(negedge clock);
      last_evt = cyc;
      bus.rx_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_seq(input bq_t q);
      foreach (q[i]) send_byte(q[i]);
   endtask

   bq_t ping, pkt;
   int  d0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [15:0] r;
         r = 16'(i) << 8;
         for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
         tbl[i] = r;
      end
      reset = 1'b0;
      bus.arm = 1'b0; bus.expected_id = 8'h00; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_params", bus.params, 32'h0);
      chk("reset_result", {29'd0, bus.result}, 32'd0);

      ping = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h07, 8'h00, 8'h55, 8'h00,
               8'h06, 8'h04, 8'h26, 8'h65, 8'h5D};

      // ping reply
      d0 = n_done;
      do_arm(8'h01);
      send_seq(ping);
      repeat (2) @(negedge clock);
      chk("ping_done", 32'(n_done - d0), 32'd1);
      chk("ping_result", {29'd0, bus.result}, 32'd0);
      chk("ping_id", {24'd0, bus.rx_id}, 32'h01);
      chk("ping_err", {24'd0, bus.rx_error}, 32'h00);
      chk("ping_count", {24'd0, bus.param_count}, 32'd3);
      chk("ping_params", bus.params, 32'h00260406);

      // bad CRC
      pkt = ping;
      pkt[13] = 8'h5C;
      do_arm(8'h01);
      send_seq(pkt);
      repeat (2) @(negedge clock);
      chk("badcrc_result", {29'd0, bus.result}, 32'd1);

      // leading junk, wrong expected id
      pkt = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
      foreach (ping[i]) pkt.push_back(ping[i]);
      d0 = n_done;
      do_arm(8'h02);
      send_seq(pkt);
      repeat (2) @(negedge clock);
      chk("junk_done", 32'(n_done - d0), 32'd1);
      chk("junk_result", {29'd0, bus.result}, 32'd3);
      chk("junk_id", {24'd0, bus.rx_id}, 32'h01);

      // length below minimum ends right after LEN_H
      d0 = n_done;
      do_arm(8'h01);
      send_seq('{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h03, 8'h00});
      chk("len3_done", 32'(n_done - d0), 32'd1);
      chk("len3_result", {29'd0, bus.result}, 32'd5);

      // stuffing and overflow
      pkt = '{8'hFF, 8'hFF, 8'hFD, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h55, 8'h00,
              8'hFF, 8'hFF, 8'hFD, 8'hFD, 8'h01, 8'h02};
      begin
         logic [15:0] c;
         c = crc_of(pkt);
         pkt.push_back(c[7:0]);
         pkt.push_back(c[15:8]);
      end
      do_arm(8'h01);
      send_seq(pkt);
      repeat (2) @(negedge clock);
      chk("stuff_count", {24'd0, bus.param_count}, 32'd5);
      chk("stuff_params", bus.params, 32'h01FDFFFF);
      chk("stuff_result", {29'd0, bus.result}, 32'd5);

      // re-arm mid-packet aborts without done
      d0 = n_done;
      do_arm(8'h01);
      for (int i = 0; i < 8; i++) send_byte(ping[i]);
      do_arm(8'h01);
      send_seq(ping);
      repeat (2) @(negedge clock);
      chk("rearm_done", 32'(n_done - d0), 32'd1);
      chk("rearm_result", {29'd0, bus.result}, 32'd0);

      // reset mid-packet
      d0 = n_done;
      do_arm(8'h01);
      for (int i = 0; i < 10; i++) send_byte(ping[i]);
      #2 reset = 1'b0;
      @(negedge clock);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_count", {24'd0, bus.param_count}, 32'd0);
      chk("rst_id", {24'd0, bus.rx_id}, 32'd0);
      #2 reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_no_done", 32'(n_done - d0), 32'd0);

      // timeout after two header bytes
      d0 = n_done;
      do_arm(8'h01);
      send_byte(8'hFF);
      send_byte(8'hFF);
      for (int i = 0; i < TMO + 20 && n_done == d0; i++) @(negedge clock);
      chk("tmo_done", 32'(n_done - d0), 32'd1);
      chk("tmo_latency", 32'(done_cyc - last_evt), 32'(TMO));
      @(negedge clock);
      chk("tmo_result", {29'd0, bus.result}, 32'd2);
      chk("tmo_busy", {31'd0, bus.busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/xl320_status_rx.md
# xl320_status_rx

Byte-level receiver and parser for Dynamixel Protocol 2.0 status packets returned by an XL-320 servo on the half-duplex bus. It sits directly downstream of the 1 Mbit `uart_rx` and consumes its `o_Rx_DV` / `o_Rx_Byte` stream. It hunts for the header, removes byte stuffing, checks ID, instruction and CRC-16, and hands the ID, error byte and parameters to the XL320 bus controller with a single completion strobe and a result code. The controller arms it when it releases the line after an instruction packet.

## Interface
- `MAX_PARAMS`, 4: number of de-stuffed parameter bytes stored.
- `TIMEOUT_CYCLES`, 50000: idle-line cycles allowed while armed (1 ms at 50 MHz).
- `clock` in 1: sole clock; one clock domain.
- `reset` in 1: reset is asynchronous and active-low. Asserted low clears all state.
- `arm` in 1: 1-cycle pulse that starts a reception; captures `expected_id`.
- `expected_id` in 8: servo ID expected in the reply.
- `rx_valid` in 1: 1-cycle byte strobe from `uart_rx`.
- `rx_byte` in 8: received byte, valid with `rx_valid`.
- `busy` out 1: high from the cycle after `arm` until `done`.
- `done` out 1: 1-cycle completion pulse.
- `result` out 3: status code. 0 OK, 1 CRC_ERR, 2 TIMEOUT, 3 ID_MISMATCH, 4 BAD_INSTR, 5 LEN_ERR.
- `rx_id` out 8: ID field of the received packet.
- `rx_error` out 8: error byte of the status packet.
- `param_count` out 8: number of de-stuffed parameter bytes received (may exceed `MAX_PARAMS`).
- `params` out 8*MAX_PARAMS: byte k occupies bits [8k+7:8k]. Unused bytes are 0.

## Operation
- **Reset:** all outputs are 0 and the state is IDLE.
- **IDLE:** `rx_valid` is ignored. `arm` clears `params`, `param_count`, `rx_id`, `rx_error` and the CRC, loads the timeout counter, and moves to H1.
- **Header hunt** (`crc` is reset to 0 on every return to H1):
  - H1: FF goes to H2; any other byte stays in H1.
  - H2: FF goes to H3; otherwise go to H1.
  - H3: FD goes to H4; FF stays in H3; otherwise go to H1.
  - H4: 00 goes to ID; FF goes to H2; otherwise go to H1.
- **Fields:** ID, then LEN_L, LEN_H, INSTR, ERR, PARAM, CRC_L, CRC_H.
  - L = {LEN_H, LEN_L} counts the bytes after LEN_H as transmitted: instr + error + stuffed params + 2 CRC bytes.
  - If L < 4, finish immediately with LEN_ERR.
  - If L == 4, go from ERR directly to CRC_L.
- **CRC:** CRC-16, poly 0x8005, init 0x0000, not reflected, no final XOR.
  - Per byte: crc = (crc<<8) ^ T[((crc>>8) ^ b) & 0xFF].
  - Covers every byte as transmitted, from the first FF through the last (stuffed) param byte.
  - The received CRC is low byte first.
- **De-stuffing:**
  - In PARAM, an FD that follows the transmitted sequence FF FF FD is dropped.
  - A dropped FD still enters the CRC and still decrements the remaining length, but is not stored or counted.
- **Params:**
  - Stored in order while `param_count` < `MAX_PARAMS`.
  - Further bytes are CRC'd and counted but not stored. This overflow sets a LEN_ERR flag.
- **Completion:** on the CRC_H byte, compare the received CRC with the computed one. The result has priority CRC_ERR > ID_MISMATCH (ID ≠ `expected_id`) > BAD_INSTR (INSTR ≠ 0x55) > LEN_ERR (overflow) > OK.
- **Timeout:**
  - The counter reloads on `arm` and on every `rx_valid` while busy.
  - If it reaches 0 while busy, finish with TIMEOUT.
  - `rx_id`, `rx_error`, `params` and `param_count` then hold whatever was captured so far.
- **Re-arm while busy:** `arm` aborts the current parse without a `done` pulse and restarts from H1.

## Timing
- One byte is processed per `rx_valid`. No backpressure exists; `rx_valid` pulses are at least 2 cycles apart (UART pacing).
- `done` and `result` are registered. `done` is high exactly one cycle, the cycle after the `rx_valid` of CRC_H (or of a LEN_H that gives L < 4).
- `busy` falls in the same cycle `done` rises.
- Timeout: `done` occurs exactly `TIMEOUT_CYCLES` cycles after the last `arm` or `rx_valid`.
- `result`, `rx_id`, `rx_error`, `params` and `param_count` are stable from `done` until the next `arm`.
- If `arm` and `rx_valid` occur in the same cycle, `arm` wins and the byte is discarded.
- If timeout expiry and `rx_valid` occur in the same cycle, the byte wins and the counter reloads.
- Reset asserted mid-packet returns to IDLE immediately, with no `done`.

## Test plan
- **Ping reply:** arm with ID 1, send FF FF FD 00 01 07 00 55 00 06 04 26 65 5D. Expect `done`, result 0, `rx_id` 01, `rx_error` 00, `param_count` 3, `params` = 00_26_04_06.
- **Bad CRC:** same packet with a final byte of 5C. Expect result 1.
- **Leading junk:** same packet preceded by 00 FF FF FF, with `expected_id` 2. Expect the header to be found, result 3 and `rx_id` 01.
- **Timeout:** arm, send FF FF, then silence. Expect `done` with result 2 exactly 50000 cycles after the second FF. `busy` is 0 afterwards.
- **Stuffing and overflow:** params FF FF FD FD 01 02, with L and CRC from the bench model. Expect `param_count` 5, stored bytes FF FF FD 01, result 5. Separately, L=0003 gives result 5 right after LEN_H.
- **Control events:** re-arm mid-packet, then send a full valid packet; expect exactly one `done`. Assert reset mid-packet; expect all outputs 0 and no `done`.
